// File: rtl/ifu_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_NPC  = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;
  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ifu_pc_reg.sv
// Architectural PC register with load enable; flags a misaligned value on the load port.
module ifu_pc_reg
  import ifu_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic            load_misaligned_o
);

  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= load_pc_i;
    end
  end

  assign pc_o              = pc_q;
  assign load_misaligned_o = (load_pc_i[1:0] != 2'b00);

endmodule

// File: rtl/ifu_fetch_unit.sv
// Fetch stage: one outstanding imem request, delivers {pc, inst} downstream, reloads pc on commit.
module ifu_fetch_unit
  import ifu_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC),
  parameter logic [31:0]     NOP_INST = IFU_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_fault,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_dnpc,
  output logic [63:0]     inst_count
);

  ifu_state_e      state_q, state_d;
  logic [31:0]     inst_q, inst_d;
  logic            fault_q, fault_d;
  logic [63:0]     count_q, count_d;
  logic            pc_load;
  logic            dnpc_misaligned;
  logic [XLEN-1:0] pc;

  ifu_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk               (clk),
    .rst               (rst),
    .load_i            (pc_load),
    .load_pc_i         (commit_dnpc),
    .pc_o              (pc),
    .load_misaligned_o (dnpc_misaligned)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      inst_q  <= NOP_INST;
      fault_q <= 1'b0;
      count_q <= 64'd0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  // A misaligned next PC never reaches the bus: it is delivered directly as a faulting NOP.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    count_d = count_q;
    pc_load = 1'b0;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_err ? NOP_INST : imem_rsp_data;
          fault_d = imem_rsp_err;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          count_d = count_q + 64'd1;
          if (commit_valid) pc_load = 1'b1;
          else              state_d = S_NPC;
        end
      end
      S_NPC: begin
        if (commit_valid) pc_load = 1'b1;
      end
      default: state_d = S_REQ;
    endcase
    if (pc_load) begin
      if (dnpc_misaligned) begin
        inst_d  = NOP_INST;
        fault_d = 1'b1;
        state_d = S_OUT;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  // The request is held off while reset is asserted so no valid is seen during reset.
  assign imem_req_valid = (state_q == S_REQ) && rst;
  assign imem_addr      = pc;
  assign out_valid      = (state_q == S_OUT);
  assign out_pc         = pc;
  assign out_inst       = inst_q;
  assign out_fault      = fault_q;
  assign inst_count     = count_q;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed self-checking bench for ifu_fetch_unit.
module tb_ifu_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic        commit_valid;
  logic [63:0] commit_dnpc;
  logic [63:0] inst_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault),
    .commit_valid   (commit_valid),
    .commit_dnpc    (commit_dnpc),
    .inst_count     (inst_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    imem_rsp_err = 1'b0; out_ready = 1'b0; commit_valid = 1'b0; commit_dnpc = 64'h0;
    #2;
    repeat (3) tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0b want 0", imem_req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_inst !== NOP) begin errors++; $display("FAIL reset_out_inst got %h want %h", out_inst, NOP); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL reset_out_fault got %0b want 0", out_fault); end
    checks++; if (inst_count !== 64'd0) begin errors++; $display("FAIL reset_count got %0d want 0", inst_count); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid got %0b want 1", imem_req_valid); end
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL release_addr got %h want %h", imem_addr, RST_PC); end
  endtask

  task automatic test_zero_wait();
    imem_req_ready = 1'b1;
    tick();
    checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL zw_wait_valids got req=%0b out=%0b want 0 0", imem_req_valid, out_valid); end
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0297;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zw_out_valid got %0b want 1", out_valid); end
    checks++; if (out_inst !== 32'h0000_0297) begin errors++; $display("FAIL zw_out_inst got %h want 00000297", out_inst); end
    checks++; if (out_pc !== RST_PC) begin errors++; $display("FAIL zw_out_pc got %h want %h", out_pc, RST_PC); end
    checks++; if (out_fault !== 1'b0) begin errors++; $display("FAIL zw_out_fault got %0b want 0", out_fault); end
    out_ready = 1'b1; commit_valid = 1'b1; commit_dnpc = RST_PC + 64'd4;
    tick();
    out_ready = 1'b0; commit_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL zw_next_req got req=%0b out=%0b want 1 0", imem_req_valid, out_valid); end
    checks++; if (imem_addr !== 64'h8000_0004) begin errors++; $display("FAIL zw_next_addr got %h want 80000004", imem_addr); end
    checks++; if (inst_count !== 64'd1) begin errors++; $display("FAIL zw_count got %0d want 1", inst_count); end
  endtask

  task automatic test_backpressure();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00a0_0093;
    tick();
    // hostile inputs while stalled: must all be ignored
    imem_rsp_data = 32'hffff_ffff; imem_req_ready = 1'b1;
    commit_valid = 1'b1; commit_dnpc = 64'h8000_0400;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_valids[%0d] got out=%0b req=%0b want 1 0", i, out_valid, imem_req_valid); end
      checks++; if (out_pc !== 64'h8000_0004 || out_inst !== 32'h00a0_0093) begin errors++; $display("FAIL bp_hold[%0d] got pc=%h inst=%h want 80000004 00a00093", i, out_pc, out_inst); end
      checks++; if (inst_count !== 64'd1) begin errors++; $display("FAIL bp_count[%0d] got %0d want 1", i, inst_count); end
      tick();
    end
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    out_ready = 1'b1; commit_dnpc = 64'h8000_0008;
    tick();
    out_ready = 1'b0; commit_valid = 1'b0;
    checks++; if (inst_count !== 64'd2) begin errors++; $display("FAIL bp_release_count got %0d want 2", inst_count); end
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0008) begin errors++; $display("FAIL bp_release_req got req=%0b addr=%h want 1 80000008", imem_req_valid, imem_addr); end
  endtask

  task automatic test_delayed_commit();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0513;
    tick();
    imem_rsp_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL npc_idle[%0d] got out=%0b req=%0b want 0 0", i, out_valid, imem_req_valid); end
      tick();
    end
    checks++; if (inst_count !== 64'd3) begin errors++; $display("FAIL npc_count got %0d want 3", inst_count); end
    commit_valid = 1'b1; commit_dnpc = 64'h8000_0100;
    tick();
    commit_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 64'h8000_0100) begin errors++; $display("FAIL npc_req got req=%0b addr=%h want 1 80000100", imem_req_valid, imem_addr); end
  endtask

  task automatic test_misaligned();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0073;
    tick();
    imem_rsp_valid = 1'b0;
    out_ready = 1'b1; commit_valid = 1'b1; commit_dnpc = 64'h8000_0102;
    tick();
    out_ready = 1'b0; commit_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_valids got out=%0b req=%0b want 1 0", out_valid, imem_req_valid); end
    checks++; if (out_fault !== 1'b1 || out_inst !== NOP) begin errors++; $display("FAIL mis_fault got fault=%0b inst=%h want 1 %h", out_fault, out_inst, NOP); end
    checks++; if (out_pc !== 64'h8000_0102) begin errors++; $display("FAIL mis_pc got %h want 80000102", out_pc); end
    checks++; if (inst_count !== 64'd4) begin errors++; $display("FAIL mis_count got %0d want 4", inst_count); end
    out_ready = 1'b1; commit_valid = 1'b1; commit_dnpc = 64'h8000_0200;
    tick();
    out_ready = 1'b0; commit_valid = 1'b0;
    checks++; if (inst_count !== 64'd5 || imem_addr !== 64'h8000_0200 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL mis_next got count=%0d addr=%h req=%0b want 5 80000200 1", inst_count, imem_addr, imem_req_valid); end
  endtask

  task automatic test_bus_error();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'hdead_beef;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_inst !== NOP) begin errors++; $display("FAIL berr_out got v=%0b fault=%0b inst=%h want 1 1 %h", out_valid, out_fault, out_inst, NOP); end
    checks++; if (out_pc !== 64'h8000_0200) begin errors++; $display("FAIL berr_pc got %h want 80000200", out_pc); end
    out_ready = 1'b1; commit_valid = 1'b1; commit_dnpc = 64'h8000_0204;
    tick();
    out_ready = 1'b0; commit_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0297;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (out_fault !== 1'b0 || out_inst !== 32'h0000_0297) begin errors++; $display("FAIL berr_clear got fault=%0b inst=%h want 0 00000297", out_fault, out_inst); end
    checks++; if (out_pc !== 64'h8000_0204 || inst_count !== 64'd6) begin errors++; $display("FAIL berr_next got pc=%h count=%0d want 80000204 6", out_pc, inst_count); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; commit_valid = 1'b1; commit_dnpc = 64'h8000_0300;
    tick();
    out_ready = 1'b0; commit_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    checks++; if (imem_req_valid !== 1'b0 || imem_addr !== 64'h8000_0300) begin errors++; $display("FAIL mid_wait got req=%0b addr=%h want 0 80000300", imem_req_valid, imem_addr); end
    #2 rst = 1'b0;
    #1;
    checks++; if (imem_addr !== RST_PC || inst_count !== 64'd0) begin errors++; $display("FAIL mid_async got addr=%h count=%0d want %h 0", imem_addr, inst_count, RST_PC); end
    checks++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_valids got req=%0b out=%0b want 0 0", imem_req_valid, out_valid); end
    tick();
    rst = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hbadc_0de0;
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || out_valid !== 1'b0 || imem_addr !== RST_PC) begin errors++; $display("FAIL mid_stale got req=%0b out=%0b addr=%h want 1 0 %h", imem_req_valid, out_valid, imem_addr, RST_PC); end
    checks++; if (out_inst !== NOP || inst_count !== 64'd0) begin errors++; $display("FAIL mid_stale_latch got inst=%h count=%0d want %h 0", out_inst, inst_count, NOP); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_delayed_commit();
    test_misaligned();
    test_bus_error();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
